// File: rtl/demux_router.sv
// 1:2 demux router: steers each accepted word into one of two output FIFOs
// by select s. Each output has its own valid/ready handshake and delivery counter.

module demux_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             rdy_i,
  output logic             full_o,
  output logic             vld_o,
  output logic [WIDTH-1:0] dout_o,
  output logic [CNTW-1:0]  cnt_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]                wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]                  occ_q, occ_d;
  logic [CNTW-1:0]              cnt_q, cnt_d;
  logic [DEPTH-1:0][WIDTH-1:0]  mem_q;
  logic                         pop;

  assign vld_o  = (occ_q != '0);
  assign full_o = (occ_q == (AW+1)'(DEPTH));
  assign pop    = vld_o & rdy_i;
  // Head is forced to zero when empty so stale storage never leaks out.
  assign dout_o = vld_o ? mem_q[rd_q] : '0;
  assign cnt_o  = cnt_q;

  always_comb begin
    wr_d  = wr_q + AW'(push_i);
    rd_d  = rd_q + AW'(pop);
    occ_d = occ_q + (AW+1)'(push_i) - (AW+1)'(pop);
    cnt_d = cnt_q + CNTW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end
endmodule

module demux_router #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic             v0,
  input  logic             r0,
  output logic [WIDTH-1:0] y1,
  output logic             v1,
  input  logic             r1,
  output logic [CNTW-1:0]  cnt0,
  output logic [CNTW-1:0]  cnt1
);
  logic [1:0]             full, vld, rdy, push;
  logic [1:0][WIDTH-1:0]  dout;
  logic [1:0][CNTW-1:0]   cnt;

  // Full flag only: a same-cycle pop does not open room for the incoming word.
  assign in_ready = ~full[s];
  assign rdy      = {r1, r0};

  for (genvar k = 0; k < 2; k++) begin : g_out
    assign push[k] = in_valid & in_ready & (s == 1'(k));
    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (push[k]),
      .din_i  (d),
      .rdy_i  (rdy[k]),
      .full_o (full[k]),
      .vld_o  (vld[k]),
      .dout_o (dout[k]),
      .cnt_o  (cnt[k])
    );
  end

  assign y0   = dout[0];
  assign y1   = dout[1];
  assign v0   = vld[0];
  assign v1   = vld[1];
  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];
endmodule

// File: tb/tb_demux_router.sv
// Scoreboard bench for demux_router: per-output expected-word queues are fed from
// accepted input and drained by a mid-cycle monitor that checks every output.

module tb_demux_router;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d;
  logic       s, in_valid, in_ready;
  logic [7:0] y0, y1;
  logic       v0, v1, r0, r1;
  logic [7:0] cnt0, cnt1;

  demux_router #(.WIDTH(8), .DEPTH(DEPTH), .CNTW(8)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .s(s), .in_valid(in_valid), .in_ready(in_ready),
    .y0(y0), .v0(v0), .r0(r0), .y1(y1), .v1(v1), .r1(r1), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int   mc0 = 0, mc1 = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: outputs must equal the reference queues; then apply this cycle's
  // handshakes to the reference as decided by the model itself.
  always @(negedge clk) begin
    if (mon_en) begin
      bit rdy_m, pop0, pop1;
      chk("v0", v0, q0.size() != 0);
      chk("v1", v1, q1.size() != 0);
      chk("y0", y0, (q0.size() != 0) ? q0[0] : 8'h00);
      chk("y1", y1, (q1.size() != 0) ? q1[0] : 8'h00);
      chk("cnt0", cnt0, mc0 % 256);
      chk("cnt1", cnt1, mc1 % 256);
      rdy_m = s ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
      chk("in_ready", in_ready, rdy_m);
      pop0 = (q0.size() != 0) && r0;
      pop1 = (q1.size() != 0) && r1;
      if (pop0) begin void'(q0.pop_front()); mc0++; end
      if (pop1) begin void'(q1.pop_front()); mc1++; end
      if (in_valid && rdy_m) begin
        if (s) q1.push_back(d); else q0.push_back(d);
      end
    end
  end

  task automatic idle(input int n, input bit rnd);
    repeat (n) begin
      if (rnd) begin
        r0 = ($urandom_range(0, 3) != 0);
        r1 = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
    end
  endtask

  // Offer one word and hold it until accepted (bounded wait).
  task automatic push(input logic [7:0] dd, input logic ss, input bit rnd);
    bit acc;
    int n;
    in_valid = 1'b1; d = dd; s = ss;
    acc = 1'b0; n = 0;
    while (!acc && n < 200) begin
      if (rnd) begin
        r0 = ($urandom_range(0, 3) != 0);
        r1 = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic clear_model();
    q0.delete(); q1.delete(); mc0 = 0; mc1 = 0;
  endtask

  initial begin
    int snap0, snap1;
    rst_n = 1'b0; d = '0; s = 1'b0; in_valid = 1'b0; r0 = 1'b0; r1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_v0", v0, 0);   chk("rst_v1", v1, 0);
    chk("rst_y0", y0, 0);   chk("rst_y1", y1, 0);
    chk("rst_cnt0", cnt0, 0); chk("rst_cnt1", cnt1, 0);
    chk("rst_ready", in_ready, 1);
    clear_model();
    mon_en = 1'b1;

    // Steering
    r0 = 1'b1; r1 = 1'b1;
    push(8'hA5, 1'b0, 1'b0);
    chk("steer_v0", v0, 1); chk("steer_y0", y0, 8'hA5);
    push(8'h3C, 1'b1, 1'b0);
    chk("steer_v1", v1, 1); chk("steer_y1", y1, 8'h3C);
    idle(3, 1'b0);
    chk("steer_cnt0", cnt0, 1); chk("steer_cnt1", cnt1, 1);

    // Full / backpressure
    r0 = 1'b0;
    push(8'h01, 1'b0, 1'b0);
    push(8'h02, 1'b0, 1'b0);
    s = 1'b0; #1 chk("full_ready_s0", in_ready, 0);
    s = 1'b1; #1 chk("full_ready_s1", in_ready, 1);
    chk("full_head", y0, 8'h01);
    idle(1, 1'b0);
    r0 = 1'b1;
    idle(4, 1'b0);

    // Simultaneous push and pop on FIFO 0 with one word held
    r0 = 1'b0;
    push(8'h55, 1'b0, 1'b0);
    r0 = 1'b1;
    push(8'h77, 1'b0, 1'b0);
    r0 = 1'b0;
    chk("pp_v0", v0, 1); chk("pp_y0", y0, 8'h77);
    s = 1'b0; #1 chk("pp_ready", in_ready, 1);
    idle(2, 1'b0);
    chk("pp_hold_y0", y0, 8'h77);
    r0 = 1'b1;
    idle(3, 1'b0);

    // Idle handshakes on empty FIFOs
    snap0 = mc0; snap1 = mc1;
    r0 = 1'b1; r1 = 1'b1;
    idle(5, 1'b0);
    chk("idle_cnt0", cnt0, snap0 % 256); chk("idle_cnt1", cnt1, snap1 % 256);
    chk("idle_y0", y0, 0); chk("idle_y1", y1, 0);

    // Reset mid-traffic
    r0 = 1'b0; r1 = 1'b0;
    push(8'h11, 1'b0, 1'b0);
    push(8'h22, 1'b1, 1'b0);
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_v0", v0, 0);   chk("mid_rst_v1", v1, 0);
    chk("mid_rst_y0", y0, 0);   chk("mid_rst_y1", y1, 0);
    chk("mid_rst_cnt0", cnt0, 0); chk("mid_rst_cnt1", cnt1, 0);
    r0 = 1'b1; r1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("mid_rst_v0_after", v0, 0);
    s = 1'b0; #1 chk("rel_ready_s0", in_ready, 1);
    s = 1'b1; #1 chk("rel_ready_s1", in_ready, 1);
    clear_model();
    mon_en = 1'b1;

    // 300-word alternating stream with random stalls
    for (int i = 0; i < 300; i++) begin
      push(8'($urandom), 1'(i % 2), 1'b1);
      if ($urandom_range(0, 3) == 0) idle(1, 1'b1);
    end
    r0 = 1'b1; r1 = 1'b1;
    idle(8, 1'b0);
    chk("wrap_cnt0", cnt0, 8'h96); chk("wrap_cnt1", cnt1, 8'h96);
    chk("wrap_q0_empty", q0.size(), 0); chk("wrap_q1_empty", q1.size(), 0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
